// File: rtl/branch_predictor_btb.sv
// Dynamic branch predictor: a direct-mapped, tagged BTB with a saturating direction
// counter per entry. It predicts from PCF in Fetch and resolves/updates from Execute.
module branch_predictor_btb #(
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 8,
  parameter int CTR_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       PCF,
  output logic              PredTakenF,
  output logic [31:0]       PredPCF,
  input  logic              BranchE,
  input  logic              TakenE,
  input  logic [31:0]       PCE,
  input  logic [31:0]       PCTargetE,
  input  logic              PredTakenE,
  input  logic [31:0]       PredPCE,
  output logic              MispredictE,
  output logic [31:0]       RedirectPCE,
  output logic              FlushD,
  output logic              FlushE,
  output logic [PERF_W-1:0] BranchCnt,
  output logic [PERF_W-1:0] MissCnt
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_ONE << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_ONE;

  logic [DEPTH-1:0] valid_reg;
  logic [TAG_W-1:0] tag_reg    [DEPTH];
  logic [31:0]      target_reg [DEPTH];
  logic [CTR_W-1:0] ctr_reg    [DEPTH];

  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;
  logic             hit_e;
  logic [CTR_W-1:0] ctr_e;
  logic [CTR_W-1:0] ctr_inc;
  logic [CTR_W-1:0] ctr_dec;
  logic             mispredict_raw;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[IDX_W+TAG_W+1:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[IDX_W+TAG_W+1:IDX_W+2];

  // Lookup reads the current table state; same-index updates become visible next cycle.
  always_comb begin
    hit_f      = valid_reg[idx_f] && (tag_reg[idx_f] == tag_f);
    PredTakenF = hit_f && ctr_reg[idx_f][CTR_W-1];
    PredPCF    = PredTakenF ? target_reg[idx_f] : PCF + 32'd4;
  end

  always_comb begin
    hit_e   = valid_reg[idx_e] && (tag_reg[idx_e] == tag_e);
    ctr_e   = ctr_reg[idx_e];
    ctr_inc = (ctr_e == CTR_MAX) ? CTR_MAX : ctr_e + CTR_ONE;
    ctr_dec = (ctr_e == '0) ? '0 : ctr_e - CTR_ONE;
  end

  // A correct direction can still be a miss when the predicted target was stale.
  always_comb begin
    mispredict_raw = (PredTakenE != TakenE) ||
                     (TakenE && PredTakenE && (PredPCE != PCTargetE));
    MispredictE    = 1'b0;
    RedirectPCE    = 32'd0;
    if (BranchE) begin
      MispredictE = mispredict_raw;
      RedirectPCE = TakenE ? PCTargetE : PCE + 32'd4;
    end
    FlushD = MispredictE;
    FlushE = MispredictE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
        ctr_reg[i]    <= CTR_WNT;
      end
    end else if (BranchE) begin
      if (hit_e) begin
        ctr_reg[idx_e] <= TakenE ? ctr_inc : ctr_dec;
        if (TakenE) begin
          target_reg[idx_e] <= PCTargetE;
        end
      end else if (TakenE) begin
        // Only taken branches allocate, so not-taken misses never evict a resident entry.
        valid_reg[idx_e]  <= 1'b1;
        tag_reg[idx_e]    <= tag_e;
        target_reg[idx_e] <= PCTargetE;
        ctr_reg[idx_e]    <= CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BranchCnt <= '0;
      MissCnt   <= '0;
    end else if (BranchE) begin
      BranchCnt <= BranchCnt + PERF_W'(1);
      if (MispredictE) begin
        MissCnt <= MissCnt + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: each step drives one Execute/Fetch cycle,
// queues the expected outputs and compares them once the combinational outputs settle.
module tb_branch_predictor_btb;
  localparam int IDX_W  = 6;
  localparam int TAG_W  = 8;
  localparam int CTR_W  = 2;
  localparam int PERF_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       PCF = 32'h100;
  logic              PredTakenF;
  logic [31:0]       PredPCF;
  logic              BranchE = 1'b0;
  logic              TakenE = 1'b0;
  logic [31:0]       PCE = 32'h0;
  logic [31:0]       PCTargetE = 32'h0;
  logic              PredTakenE = 1'b0;
  logic [31:0]       PredPCE = 32'h0;
  logic              MispredictE;
  logic [31:0]       RedirectPCE;
  logic              FlushD;
  logic              FlushE;
  logic [PERF_W-1:0] BranchCnt;
  logic [PERF_W-1:0] MissCnt;

  branch_predictor_btb #(
    .IDX_W(IDX_W), .TAG_W(TAG_W), .CTR_W(CTR_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(PredTakenF), .PredPCF(PredPCF),
    .BranchE(BranchE), .TakenE(TakenE), .PCE(PCE), .PCTargetE(PCTargetE),
    .PredTakenE(PredTakenE), .PredPCE(PredPCE), .MispredictE(MispredictE),
    .RedirectPCE(RedirectPCE), .FlushD(FlushD), .FlushE(FlushE),
    .BranchCnt(BranchCnt), .MissCnt(MissCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic expect_v(input string n, input logic [31:0] v);
    exp_t e;
    e.name  = n;
    e.value = v;
    sb.push_back(e);
  endtask

  task automatic observe(input string n, input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s no queued expectation, observed=%0h", n, obs);
    end else begin
      e = sb.pop_front();
      assert (e.name == n && obs === e.value) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h (%s)", n, obs, e.value, e.name);
      end
    end
  endtask

  task automatic expect_all(input logic mis, input logic [31:0] redir, input logic ptf,
                            input logic [31:0] ppc, input int bc, input int mc);
    expect_v("MispredictE", {31'd0, mis});
    expect_v("FlushD",      {31'd0, mis});
    expect_v("FlushE",      {31'd0, mis});
    expect_v("RedirectPCE", redir);
    expect_v("PredTakenF",  {31'd0, ptf});
    expect_v("PredPCF",     ppc);
    expect_v("BranchCnt",   32'(bc));
    expect_v("MissCnt",     32'(mc));
  endtask

  task automatic observe_all();
    observe("MispredictE", {31'd0, MispredictE});
    observe("FlushD",      {31'd0, FlushD});
    observe("FlushE",      {31'd0, FlushE});
    observe("RedirectPCE", RedirectPCE);
    observe("PredTakenF",  {31'd0, PredTakenF});
    observe("PredPCF",     PredPCF);
    observe("BranchCnt",   32'(BranchCnt));
    observe("MissCnt",     32'(MissCnt));
  endtask

  // Called 1 time unit after a rising edge; counters and lookup reflect state before
  // this cycle's update. Leaves time at 1 unit after the next rising edge.
  task automatic step(input logic [31:0] pcf, input logic br, input logic [31:0] pce,
                      input logic tk, input logic [31:0] tgt, input logic ptk,
                      input logic [31:0] ppc, input logic e_mis, input logic [31:0] e_redir,
                      input logic e_ptf, input logic [31:0] e_ppc, input int e_bc,
                      input int e_mc);
    PCF        = pcf;
    BranchE    = br;
    PCE        = pce;
    TakenE     = tk;
    PCTargetE  = tgt;
    PredTakenE = ptk;
    PredPCE    = ppc;
    expect_all(e_mis, e_redir, e_ptf, e_ppc, e_bc, e_mc);
    #3;
    observe_all();
    $display("step pcf=%h br=%0d pce=%h tk=%0d tgt=%h -> mis=%0d redir=%h ptf=%0d ppc=%h bc=%0d mc=%0d",
             pcf, br, pce, tk, tgt, MispredictE, RedirectPCE, PredTakenF, PredPCF,
             BranchCnt, MissCnt);
    @(posedge clk);
    #1;
    BranchE = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // pcf, br, pce, tk, tgt, ptk, ppc | mis, redir, ptf, ppc, bc, mc
    step(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 0);
    // cold taken branch; lookup on same index still sees the old (empty) entry
    step(32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h104, 1, 32'h80,  0, 32'h104, 0, 0);
    step(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h80,  1, 1);
    // taken x3 saturates at 3
    step(32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  0, 32'h80,  1, 32'h80,  1, 1);
    step(32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  0, 32'h80,  1, 32'h80,  2, 1);
    step(32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  0, 32'h80,  1, 32'h80,  3, 1);
    // not taken: 3 -> 2, still predicts taken
    step(32'h100, 1, 32'h100, 0, 32'h80,  1, 32'h80,  1, 32'h104, 1, 32'h80,  4, 1);
    // not taken: 2 -> 1
    step(32'h100, 1, 32'h100, 0, 32'h80,  1, 32'h80,  1, 32'h104, 1, 32'h80,  5, 2);
    step(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 6, 3);
    // taken again: 1 -> 2
    step(32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h104, 1, 32'h80,  0, 32'h104, 6, 3);
    // right direction, wrong target
    step(32'h100, 1, 32'h100, 1, 32'h90,  1, 32'h80,  1, 32'h90,  1, 32'h80,  7, 4);
    step(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h90,  8, 5);
    // alias at the same index replaces the resident entry
    step(32'h100, 1, 32'h200, 1, 32'h200, 0, 32'h204, 1, 32'h200, 1, 32'h90,  8, 5);
    step(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 9, 6);
    step(32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200, 9, 6);
    // not-taken miss keeps the resident entry and allocates nothing
    step(32'h200, 1, 32'h300, 0, 32'h40,  0, 32'h304, 0, 32'h304, 1, 32'h200, 9, 6);
    step(32'h300, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h304, 10, 6);
    step(32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200, 10, 6);
    // non-branch with a matching PCE must not touch the table or outputs
    step(32'h200, 0, 32'h200, 0, 32'h44,  1, 32'h48,  0, 32'h0,   1, 32'h200, 10, 6);
    step(32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200, 10, 6);

    // asynchronous reset asserted between edges
    #2;
    rst_n = 1'b0;
    expect_v("PredTakenF", 32'd0);
    expect_v("PredPCF",    32'h204);
    expect_v("BranchCnt",  32'd0);
    expect_v("MissCnt",    32'd0);
    #1;
    observe("PredTakenF", {31'd0, PredTakenF});
    observe("PredPCF",    PredPCF);
    observe("BranchCnt",  32'(BranchCnt));
    observe("MissCnt",    32'(MissCnt));
    $display("async reset: ptf=%0d ppc=%h bc=%0d mc=%0d", PredTakenF, PredPCF, BranchCnt, MissCnt);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h204, 0, 0);
    step(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 0);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline.
- Combines a direct-mapped, tagged branch target buffer (BTB) with a per-entry saturating direction counter.
- Predicts in Fetch from PCF and resolves and updates in Execute.
- Signals a mispredict with a redirect PC and D/E flushes, and keeps branch/mispredict performance counters.

Parameters:
- IDX_W, 6, index bits; table depth = 2^IDX_W entries.
- TAG_W, 8, tag bits stored per entry.
- CTR_W, 2, direction counter width (>=1).
- PERF_W, 32, width of performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PCF  in  32  fetch PC to predict.
- PredTakenF  out  1  prediction for PCF: taken.
- PredPCF  out  32  next PC: BTB target if PredTakenF, else PCF+4.
- BranchE  in  1  instruction in E is a conditional branch (B-type).
- TakenE  in  1  resolved outcome of the branch in E.
- PCE  in  32  PC of the instruction in E.
- PCTargetE  in  32  resolved branch target in E.
- PredTakenE  in  1  PredTakenF carried by the datapath to E.
- PredPCE  in  32  PredPCF carried by the datapath to E.
- MispredictE  out  1  branch in E was mispredicted.
- RedirectPCE  out  32  correct next PC when MispredictE.
- FlushD  out  1  flush the D stage.
- FlushE  out  1  flush the E stage.
- BranchCnt  out  PERF_W  resolved branches since reset.
- MissCnt  out  PERF_W  mispredicts since reset.

Behaviour:
- Address split:
  - idx = PC[IDX_W+1:2].
  - tag = PC[IDX_W+TAG_W+1:IDX_W+2].
  - PC[1:0] is ignored.
- Entry contents: valid, tag[TAG_W], target[32], ctr[CTR_W].
- Lookup (combinational, asynchronous read of the current table state):
  - hit = valid[idxF] & tag match.
  - PredTakenF = hit & ctr MSB.
  - PredPCF = PredTakenF ? target : PCF+4 (mod 2^32).
- Resolution (combinational, qualified by BranchE; all outputs are 0 when BranchE=0):
  - MispredictE = (PredTakenE != TakenE) | (TakenE & PredTakenE & PredPCE != PCTargetE).
  - RedirectPCE = TakenE ? PCTargetE : PCE+4.
  - FlushD = FlushE = MispredictE.
- Update at posedge clk when BranchE=1, on the entry selected by idxE:
  - Hit, taken: ctr = min(ctr+1, 2^CTR_W-1); target = PCTargetE.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate and overwrite the entry. valid=1, tag=tagE, target=PCTargetE, ctr = weakly-taken (MSB=1, rest 0, i.e. 2'b10).
  - Miss, not taken: no change; a non-matching resident entry is kept.
- Perf counters at posedge clk:
  - BranchE increments BranchCnt.
  - BranchE & MispredictE increments MissCnt.
  - Both wrap modulo 2^PERF_W.
- Same-cycle read/write to the same index (idxF == idxE): the Fetch lookup sees the pre-update state (no bypass). The new state is visible from the next cycle.
- Reset (async assert, sync-to-clk deassert by the top level):
  - All valid=0 and all ctr = weakly-not-taken (MSB=0, rest 1, i.e. 2'b01).
  - target and tag cleared to 0.
  - BranchCnt=MissCnt=0.
  - Outputs go immediately to PredTakenF=0 and PredPCF=PCF+4.
- Reset mid-operation discards all history. Any update pending for that edge is lost.
- Non-branch instructions (BranchE=0) never modify the table, even with an arbitrary PCE.
- CTR_W=1 degenerates to a 1-bit last-outcome predictor: weakly-taken = 1, weakly-not-taken = 0.

Test Plan:
- Reset then PCF=0x100 -> PredTakenF=0, PredPCF=0x104; BranchCnt=MissCnt=0.
- Cold branch: BranchE=1, PCE=0x100, TakenE=1, PCTargetE=0x80, PredTakenE=0, PredPCE=0x104.
  - Same cycle: MispredictE=FlushD=FlushE=1, RedirectPCE=0x80.
  - Next cycle, PCF=0x100: PredTakenF=1, PredPCF=0x80; MissCnt=1.
- Saturation and hysteresis:
  - Resolve 0x100 taken ×3 -> ctr=3.
  - Then not taken once: mispredict, RedirectPCE=0x104, ctr=2, still PredTakenF=1.
  - Second not-taken -> ctr=1, PredTakenF=0.
- Aliasing:
  - 0x100 resident.
  - Resolve PCE=0x100+(1<<(IDX_W+2)) taken, target 0x200 -> entry replaced.
  - PCF=0x100 -> PredTakenF=0 (tag miss).
  - Not-taken miss on a fresh PC -> table unchanged.
- Wrong target: PredTakenE=1, PredPCE=0x80, TakenE=1, PCTargetE=0x90 -> MispredictE=1, RedirectPCE=0x90; next lookup gives PredPCF=0x90.
- Same-index collision and reset:
  - Update and lookup the same idx in one cycle -> lookup returns the old value.
  - Assert rst_n=0 mid-run, off-edge -> PredTakenF drops to 0 immediately; counters reset to 0.
